mdiv_seq_ctrl: RTL
==================

Name: mdiv_seq_ctrl

Overview:
- Sequencer in front of the 256-bit modular inverse/division engine (MINV_MDIV).
- Accepts one command from a host and streams operands p, a and (for division) b into the engine, 32 bits per cycle.
- Pulses the start strobe and waits for completion under a timeout.
- Drains the 8-word result back to the host over a valid/ready stream.

Parameters:
- WORDS, 8, 32-bit words per 256-bit operand and result.
- TO_W, 20, width of the completion-timeout counter.
- TO_MAX, 20'hFFFFF, number of WAIT cycles before a timeout is declared.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command request.
- cmd_op  in  1  1 = modular inverse, 0 = modular division.
- cmd_ready  out  1  high only in IDLE.
- in_valid  in  1  operand word valid.
- in_data  in  32  operand word, least-significant word first.
- in_ready  out  1  high in the LD_P, LD_A and LD_B states.
- res_valid  out  1  result word valid.
- res_data  out  32  result word, least-significant word first.
- res_last  out  1  marks the 8th result word.
- res_ready  in  1  host accepts the result word.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last result word is accepted.
- timeout  out  1  one-cycle pulse when the engine fails to finish.
- eng_datain  out  32  to engine datain.
- eng_loada  out  1  to engine loada.
- eng_loadb  out  1  to engine loadb.
- eng_loadp  out  1  to engine loadp.
- eng_minv_mdiv  out  1  registered cmd_op.
- eng_en  out  1  engine start pulse.
- eng_rdy  in  1  engine minv_mdiv_rdy.
- eng_result  in  32  engine result_out.
- eng_out_valid  in  1  engine out_valid.
- eng_out_ready  out  1  engine out_ready.

Behaviour:
- States: IDLE, LD_P, LD_A, LD_B, START, WAIT, DRAIN. Encoding is held in a 3-bit register. A 3-bit word counter wcnt and a TO_W timeout counter tcnt support the states.
- Reset (rst=0, asynchronous): state=IDLE, wcnt=0, tcnt=0, op register=0. All outputs are 0 except cmd_ready=1. Reset mid-operation abandons the transfer immediately and is the only abort mechanism.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_op into the op register, clear wcnt, and go to LD_P.
- Load handshake:
  - A word fires when in_valid && in_ready.
  - eng_datain = in_data combinationally.
  - The state's load strobe (eng_loadp / eng_loada / eng_loadb) is high only in the fire cycle.
  - Each fire increments wcnt.
  - Stalls (in_valid=0) hold the state and wcnt.
- Load transitions:
  - LD_P: on the WORDS-th fire, go to LD_A and clear wcnt.
  - LD_A: on the WORDS-th fire, go to START if op=1, else go to LD_B.
  - LD_B: on the WORDS-th fire, go to START.
  - Inverse loads exactly 16 words; division loads exactly 24.
- START: eng_en=1 for exactly one cycle, clear tcnt, go to WAIT.
- WAIT:
  - tcnt increments every cycle.
  - eng_rdy is ignored while tcnt==0 (stale rdy from the previous operation).
  - If eng_rdy=1 and tcnt>=1: go to DRAIN and clear wcnt.
  - Else if tcnt==TO_MAX: pulse timeout and go to IDLE. The engine state is then undefined and the host must reset.
  - If rdy and TO_MAX coincide, rdy wins.
- DRAIN:
  - res_valid = eng_out_valid; res_data = eng_result; eng_out_ready = res_ready. All three are combinational pass-through, valid only in DRAIN.
  - A beat fires on res_valid && res_ready and increments wcnt.
  - res_last = (wcnt==WORDS-1).
  - On the firing beat with res_last: the next cycle is IDLE, and done pulses for one cycle in that IDLE cycle.
  - The engine must not be fired more than WORDS times.
- eng_minv_mdiv = op register, held stable from IDLE exit until the next command.
- Simultaneous events:
  - cmd_valid outside IDLE is ignored (cmd_ready=0).
  - in_valid outside the load states is ignored.
- Width: wcnt counts 0..WORDS-1 with no wrap beyond WORDS; tcnt saturates at TO_MAX.

Decomposition:
- Package mdiv_pkg:
  - state encoding constants ST_IDLE..ST_DRAIN.
  - OP_INV=1, OP_DIV=0.
  - default WORDS and TO_MAX values.
- No sub-module is required. The counters are inline.
- Integration test instantiates MINV_MDIV beneath mdiv_seq_ctrl.

Test Plan:
- Inverse, p=FFFFFFFF_00000001_..., a=3, host streams 16 words with no gaps -> eng_loadp high on cycles 1-8 after accept, eng_loada on cycles 9-16; one eng_en pulse; 8 results with res_last on the 8th; done pulse; result*3 mod p == 1.
- Division, 24 words with in_valid deasserted every other cycle -> load strobes only on fire cycles, eng_loadb exactly 8 pulses; result equals b*a^-1 mod p; eng_minv_mdiv=0 throughout.
- Backpressure: res_ready toggles 1,0,0,1... -> no result word lost or duplicated; eng_out_ready mirrors res_ready; res_last on the 8th accepted beat only.
- Timeout: TO_MAX=100, eng_rdy held 0 -> timeout pulses once 101 cycles after eng_en; state returns to IDLE; no res_valid.
- Stale rdy: eng_rdy held 1 into START -> FSM stays in WAIT for the tcnt==0 cycle, enters DRAIN on the next cycle.
- Async reset mid-LD_A (after word 5) -> all outputs drop in the same cycle, cmd_ready=1; a new full inverse command then completes correctly.

Source files
------------

// File: rtl/mdiv_pkg.sv
// Shared types and defaults for the MINV_MDIV command sequencer.
package mdiv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LD_P  = 3'd1,
      ST_LD_A  = 3'd2,
      ST_LD_B  = 3'd3,
      ST_START = 3'd4,
      ST_WAIT  = 3'd5,
      ST_DRAIN = 3'd6
   } state_e;

   localparam logic OP_INV = 1'b1;
   localparam logic OP_DIV = 1'b0;

   localparam int unsigned WORDS_DEF  = 8;
   localparam int unsigned TO_W_DEF   = 20;
   localparam logic [19:0] TO_MAX_DEF = 20'hFFFFF;

endpackage

// File: rtl/mdiv_seq_ctrl.sv
// Command sequencer for the MINV_MDIV engine: streams operands in, starts the engine,
// waits for completion under a timeout and drains the result to the host.
module mdiv_seq_ctrl
   import mdiv_pkg::*;
#(
   parameter int unsigned     WORDS  = WORDS_DEF,
   parameter int unsigned     TO_W   = TO_W_DEF,
   parameter logic [TO_W-1:0] TO_MAX = TO_W'(TO_MAX_DEF)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic        cmd_op,
   output logic        cmd_ready,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic        res_last,
   input  logic        res_ready,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [31:0] eng_datain,
   output logic        eng_loada,
   output logic        eng_loadb,
   output logic        eng_loadp,
   output logic        eng_minv_mdiv,
   output logic        eng_en,
   input  logic        eng_rdy,
   input  logic [31:0] eng_result,
   input  logic        eng_out_valid,
   output logic        eng_out_ready
);

   localparam int unsigned WW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [WW-1:0] WLAST = WW'(WORDS - 1);

   state_e          state_q, state_d;
   logic [WW-1:0]   wcnt_q, wcnt_d;
   logic [TO_W-1:0] tcnt_q, tcnt_d;
   logic            op_q, op_d;
   logic            done_q, done_d;
   logic            wlast;

   assign wlast         = (wcnt_q == WLAST);
   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign eng_minv_mdiv = op_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
         tcnt_q  <= '0;
         op_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         tcnt_q  <= tcnt_d;
         op_q    <= op_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wcnt_d        = wcnt_q;
      tcnt_d        = tcnt_q;
      op_d          = op_q;
      done_d        = 1'b0;
      cmd_ready     = 1'b0;
      in_ready      = 1'b0;
      eng_datain    = '0;
      eng_loadp     = 1'b0;
      eng_loada     = 1'b0;
      eng_loadb     = 1'b0;
      eng_en        = 1'b0;
      timeout       = 1'b0;
      res_valid     = 1'b0;
      res_data      = '0;
      res_last      = 1'b0;
      eng_out_ready = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d    = cmd_op;
               wcnt_d  = '0;
               state_d = ST_LD_P;
            end
         end

         ST_LD_P, ST_LD_A, ST_LD_B: begin
            in_ready   = 1'b1;
            eng_datain = in_data;
            eng_loadp  = in_valid && (state_q == ST_LD_P);
            eng_loada  = in_valid && (state_q == ST_LD_A);
            eng_loadb  = in_valid && (state_q == ST_LD_B);
            if (in_valid) begin
               if (wlast) begin
                  wcnt_d = '0;
                  if (state_q == ST_LD_P) begin
                     state_d = ST_LD_A;
                  end else if (state_q == ST_LD_A && op_q != OP_INV) begin
                     state_d = ST_LD_B;
                  end else begin
                     state_d = ST_START;
                  end
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end

         ST_START: begin
            eng_en  = 1'b1;
            tcnt_d  = '0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            if (tcnt_q != TO_MAX) begin
               tcnt_d = tcnt_q + 1'b1;
            end
            // rdy seen in the first WAIT cycle may be left over from the previous operation
            if (eng_rdy && tcnt_q != '0) begin
               wcnt_d  = '0;
               state_d = ST_DRAIN;
            end else if (tcnt_q == TO_MAX) begin
               timeout = 1'b1;
               state_d = ST_IDLE;
            end
         end

         ST_DRAIN: begin
            res_valid     = eng_out_valid;
            res_data      = eng_result;
            eng_out_ready = res_ready;
            res_last      = wlast;
            if (eng_out_valid && res_ready) begin
               if (wlast) begin
                  wcnt_d  = '0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule
